// File: rtl/addr_unsigned_serial_tr.sv
// Digit-serial unsigned adder with time redundancy: two passes, compare, bounded retry.
// Optional build macro ADDR_SERIAL_FAULT_INJECT_EN adds an inject port that corrupts PASS2 digits.
module addr_unsigned_serial_tr #(
   parameter int WIDTH     = 8,
   parameter int DIGIT     = 2,
   parameter int MAX_RETRY = 2,
   localparam int RW       = ($clog2(MAX_RETRY + 1) > 1) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             fault,
   output logic [RW-1:0]    retries,
   output logic [2:0]       dbg_state
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
   ,
   input  logic             inject
`endif
);

   localparam int D  = WIDTH / DIGIT;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PASS1 = 3'd1;
   localparam logic [2:0] PASS2 = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid and the result stay stable until out_ready is seen.
   logic [2:0]       state;
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH:0]   res1, res2;
   logic             c1, c2;
   logic [CW-1:0]    k;
   logic [RW-1:0]    rcnt;
   logic             fault_q;

   logic [DIGIT-1:0] a_k, b_k, d2;
   logic [DIGIT:0]   s1, s2;
   logic             last;

   always_comb begin
      a_k  = op_a[k*DIGIT +: DIGIT];
      b_k  = op_b[k*DIGIT +: DIGIT];
      s1   = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, c1};
      // Second pass uses swapped operand order and its own carry chain.
      s2   = {1'b0, b_k} + {1'b0, a_k} + {{DIGIT{1'b0}}, c2};
      d2   = s2[DIGIT-1:0];
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      d2[0] = s2[0] ^ inject;
`endif
      last = (k == CW'(D - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_a    <= '0;
         op_b    <= '0;
         res1    <= '0;
         res2    <= '0;
         c1      <= 1'b0;
         c2      <= 1'b0;
         k       <= '0;
         rcnt    <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a    <= a;
                  op_b    <= b;
                  rcnt    <= '0;
                  fault_q <= 1'b0;
                  k       <= '0;
                  c1      <= 1'b0;
                  state   <= PASS1;
               end
            end
            PASS1: begin
               res1[k*DIGIT +: DIGIT] <= s1[DIGIT-1:0];
               if (last) begin
                  res1[WIDTH] <= s1[DIGIT];
                  c1          <= 1'b0;
                  c2          <= 1'b0;
                  k           <= '0;
                  state       <= PASS2;
               end else begin
                  c1 <= s1[DIGIT];
                  k  <= k + CW'(1);
               end
            end
            PASS2: begin
               res2[k*DIGIT +: DIGIT] <= d2;
               if (last) begin
                  res2[WIDTH] <= s2[DIGIT];
                  c2          <= 1'b0;
                  k           <= '0;
                  state       <= CHECK;
               end else begin
                  c2 <= s2[DIGIT];
                  k  <= k + CW'(1);
               end
            end
            CHECK: begin
               if (res1 == res2) begin
                  fault_q <= 1'b0;
                  state   <= DONE;
               end else if (32'(rcnt) < MAX_RETRY) begin
                  // Retry recomputes both passes from the latched operands.
                  rcnt  <= rcnt + RW'(1);
                  c1    <= 1'b0;
                  state <= PASS1;
               end else begin
                  fault_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign sum       = res1;
   assign fault     = fault_q;
   assign retries   = rcnt;
   assign dbg_state = state;

endmodule

// File: tb/tb_addr_unsigned_serial_tr.sv
// Bench for addr_unsigned_serial_tr: vector table, scoreboard queue, latency and handshake checks.
module tb_addr_unsigned_serial_tr;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int D     = WIDTH / DIGIT;
   localparam int RW    = 2;
   localparam int W     = WIDTH + 1 + 1 + RW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH:0]   sum;
   logic             fault;
   logic [RW-1:0]    retries;
   logic [2:0]       dbg_state;
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
   logic             inject = 1'b0;
`endif

   addr_unsigned_serial_tr #(.WIDTH(WIDTH), .DIGIT(DIGIT), .MAX_RETRY(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .fault(fault), .retries(retries), .dbg_state(dbg_state)
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      , .inject(inject)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [W-1:0] exp_q[$];
   int           lat_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge, away from the active edge.
   int   cyc = 0;
   int   acc_cyc = 0;
   int   lat_meas = 0;
   logic busy = 1'b0;
   logic ov_prev = 1'b0;
   logic hs_prev = 1'b0;

   always @(negedge clk) begin
      logic         hs;
      logic [W-1:0] e;
      int           el;
      cyc++;
      if (rst) begin
         chk("in_ready_in_reset", 32'(in_ready), 32'd0);
         exp_q.delete();
         lat_q.delete();
         busy    = 1'b0;
         ov_prev = 1'b0;
         hs_prev = 1'b0;
      end else begin
         chk("in_ready_model", 32'(in_ready), 32'(!busy));
         if (hs_prev) chk("out_valid_drop", 32'(out_valid), 32'd0);
         if (out_valid && !ov_prev) lat_meas = cyc - acc_cyc;
         hs = out_valid && out_ready;
         if (hs) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
            end else begin
               e  = exp_q.pop_front();
               el = lat_q.pop_front();
               chk("sum", 32'(sum), 32'(e[W-1 -: WIDTH+1]));
               chk("fault", 32'(fault), 32'(e[RW]));
               chk("retries", 32'(retries), 32'(e[RW-1:0]));
               chk("latency", 32'(lat_meas), 32'(el));
            end
            busy = 1'b0;
         end
         if (in_valid && in_ready) begin
            busy    = 1'b1;
            acc_cyc = cyc;
         end
         ov_prev = out_valid;
         hs_prev = hs;
      end
   end

   // inj: 0 none, 1 one PASS2 cycle of the first attempt, 2 held high until drained
   task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [8:0] es,
                        input logic ef, input logic [RW-1:0] er, input int lat, input int inj);
      logic acc;
      exp_q.push_back({es, ef, er});
      lat_q.push_back(lat);
      a = va;
      b = vb;
      in_valid = 1'b1;
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      if (inj == 2) inject = 1'b1;
`endif
      acc = 1'b0;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      if (inj == 1) begin
         repeat (D) @(posedge clk);
         #1 inject = 1'b1;
         @(posedge clk);
         #1 inject = 1'b0;
      end
`endif
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      inject = 1'b0;
`endif
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [8:0] s;
   } vec_t;

   vec_t tv[5];

   initial begin
      logic [7:0] ra, rb;
      logic       seen;

      tv[0] = '{8'hFF, 8'h01, 9'h100};
      tv[1] = '{8'h00, 8'h00, 9'h000};
      tv[2] = '{8'hAA, 8'h55, 9'h0FF};
      tv[3] = '{8'h7F, 8'h7F, 9'h0FE};
      tv[4] = '{8'h01, 8'hFF, 9'h100};

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_retries", 32'(retries), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;

      // table vectors, issued back to back
      for (int i = 0; i < 5; i++)
         do_op(tv[i].va, tv[i].vb, tv[i].s, 1'b0, 2'd0, 2*D+2, 0);
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         do_op(ra, rb, {1'b0, ra} + {1'b0, rb}, 1'b0, 2'd0, 2*D+2, 0);
      end
      wait_drain();

      // back-pressure: result held while out_ready is low
      out_ready = 1'b0;
      do_op(8'h80, 8'h80, 9'h100, 1'b0, 2'd0, 2*D+2, 0);
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("bp_out_valid_seen", 32'(seen), 32'd1);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_sum", 32'(sum), 32'h100);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_idle_after", 32'(dbg_state), 32'd0);
      wait_drain();

`ifdef ADDR_SERIAL_FAULT_INJECT_EN
      do_op(8'h3C, 8'h0F, 9'h04B, 1'b0, 2'd1, 4*D+3, 1);
      wait_drain();
      do_op(8'h12, 8'h34, 9'h046, 1'b1, 2'd2, 6*D+4, 2);
      wait_drain();
`endif

      // reset during PASS2 aborts the operation
      do_op(8'hFF, 8'hFF, 9'h1FE, 1'b0, 2'd0, 2*D+2, 0);
      repeat (D + 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      do_op(8'h01, 8'h02, 9'h003, 1'b0, 2'd0, 2*D+2, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addr_unsigned_serial_tr.md
Name: addr_unsigned_serial_tr

Overview:
- Parametrised, digit-serial unsigned adder for the fault-resilient adder family. Adds DIGIT bits per clock.
- Uses time redundancy: each addition is computed twice, the second time with operands swapped and an independent carry register, and the two results are compared.
- A mismatch triggers a bounded retry. Results that still disagree are flagged as faulty.
- Sits between valid/ready stages wherever a small, fault-detecting adder is preferred over a wide combinational one.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits processed per cycle; must divide WIDTH. D = WIDTH/DIGIT cycles per pass.
- MAX_RETRY, 2: extra attempt pairs allowed after the first mismatch; must be ≥ 0.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands a/b valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: operand A, unsigned.
- b, input, WIDTH: operand B, unsigned.
- out_valid, output, 1: sum/fault/retries valid.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH+1: a+b; MSB is the carry-out.
- fault, output, 1: passes still disagreed after MAX_RETRY retries.
- retries, output, RW = max(1, $clog2(MAX_RETRY+1)): retries consumed for this result.

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - in_ready=0 while rst=1, and 1 in the first cycle after rst falls.
  - out_valid=0, sum=0, fault=0, retries=0.
  - All internal registers and the FSM (state = IDLE) are cleared.
- FSM states: IDLE, PASS1, PASS2, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b, clear the retry counter, go to PASS1.
- PASS1 (D cycles, digit index k = 0..D-1, LSB digit first):
  - res1[k*DIGIT +: DIGIT] = a_k + b_k + c1.
  - c1 starts at 0 each pass. At the last digit the final carry goes to res1[WIDTH].
- PASS2 (D cycles): same digit sequence, computed as b_k + a_k + c2, with separate carry register c2 and result register res2.
- CHECK (1 cycle): compare res1 with res2.
  - Equal: go to DONE, fault=0.
  - Unequal and retry count < MAX_RETRY: increment retry count, go to PASS1; both passes recompute from the latched operands.
  - Unequal and retry count == MAX_RETRY: go to DONE, fault=1.
- DONE:
  - out_valid=1; sum=res1; retries = retry count.
  - Outputs are held stable until out_valid&&out_ready, then go to IDLE. out_valid drops the following cycle.
- in_ready=0 in every state except IDLE; no overlap between consecutive operations.
- Latency:
  - No retry: out_valid first asserts 2D+2 cycles after the accepting edge (10 cycles for the defaults).
  - Each retry adds 2D+1 cycles.
- Width and arithmetic:
  - Full-width unsigned addition; no overflow is possible in WIDTH+1 bits.
  - Wrap-around of the digit index happens only between passes.
- Boundary conditions:
  - in_valid asserted outside IDLE is ignored; operands are not sampled.
  - out_ready held high continuously gives a one-cycle DONE.
  - rst during any state aborts the operation: no out_valid, partial results discarded, state = IDLE.
  - rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: ADDR_SERIAL_FAULT_INJECT_EN.
- Defined:
  - Adds input port inject (1 bit).
  - When inject=1 during a PASS2 cycle, bit 0 of that cycle's res2 digit is inverted before it is stored.
  - Used to exercise the retry and fault paths.
- Undefined: port absent; no inversion logic is synthesised.
- Normal (fault-free) behaviour is identical in both builds.

Test Plan:
- Reset, then a=8'hFF, b=8'h01, out_ready=1 → sum=9'h100, fault=0, retries=0; out_valid exactly 10 cycles after acceptance, for one cycle.
- a=8'h00, b=8'h00, then a=8'hAA, b=8'h55 back to back → sums 9'h000 then 9'h0FF. Second acceptance only occurs after the first handshake; in_ready=0 throughout.
- a=8'h80, b=8'h80, out_ready held low 5 cycles after out_valid → sum=9'h100 held stable; out_valid stays 1; in_ready stays 0; IDLE reached the cycle after out_ready rises.
- (ADDR_SERIAL_FAULT_INJECT_EN) a=8'h3C, b=8'h0F, inject=1 for one PASS2 cycle of the first attempt only → sum=9'h04B, fault=0, retries=1, latency 19 cycles.
- (ADDR_SERIAL_FAULT_INJECT_EN) a=8'h12, b=8'h34, inject=1 during every PASS2 → fault=1, retries=2, sum=9'h046, latency 28 cycles.
- Assert rst for one cycle during PASS2 of a=8'hFF, b=8'hFF → out_valid never rises for it; in_ready=1 the cycle after rst falls; next operation a=8'h01, b=8'h02 gives 9'h003.
